// File: rtl/qfix_pkg.sv
// rtl/qfix_pkg.sv - shared fixed-point constants and saturation helper for the qadd blocks
package qfix_pkg;

  // Widest lane the helpers support; lanes pass their real width in n.
  localparam int QFIX_MAX_W = 64;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic logic [QFIX_MAX_W-1:0] sat_max(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [QFIX_MAX_W-1:0] sat_min(input int n);
    return 64'd1 << (n - 1);
  endfunction

  // s holds an (n+1)-bit sum in its low bits; returns {ovf, n-bit result in low bits}.
  function automatic logic [QFIX_MAX_W:0] sat_clip(input logic [QFIX_MAX_W:0] s,
                                                   input int n, input logic sat);
    logic [6:0]            idx_top;
    logic [6:0]            idx_msb;
    logic                  ovf;
    logic [QFIX_MAX_W-1:0] r;
    idx_top = 7'(n);
    idx_msb = 7'(n - 1);
    ovf     = s[idx_top] ^ s[idx_msb];
    r       = s[QFIX_MAX_W-1:0];
    if (sat && ovf) begin
      r = s[idx_top] ? sat_min(n) : sat_max(n);
    end
    return {ovf, r};
  endfunction

endpackage

// File: rtl/qadd_lane.sv
// rtl/qadd_lane.sv - one lane: widened add/sub for stage 1, overflow detect and clamp for stage 2
module qadd_lane
  import qfix_pkg::*;
#(
  parameter int N   = 32,
  parameter int SAT = 1
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  output logic [N:0]   s_o,
  input  logic [N:0]   s_i,
  output logic [N-1:0] c_o,
  output logic         ovf_o
);

  logic [N:0]          a_x;
  logic [N:0]          b_x;
  logic [QFIX_MAX_W:0] s_w;
  logic [QFIX_MAX_W:0] r_w;

  // One extra bit keeps a - (most negative) representable before clamping.
  assign a_x = {a_i[N-1], a_i};
  assign b_x = {b_i[N-1], b_i};
  assign s_o = (sub_i == OP_SUB) ? (a_x + ~b_x + {{N{1'b0}}, 1'b1}) : (a_x + b_x);

  assign s_w   = (QFIX_MAX_W+1)'(s_i);
  assign r_w   = sat_clip(s_w, N, SAT != 0);
  assign c_o   = r_w[N-1:0];
  assign ovf_o = r_w[QFIX_MAX_W];

  if (N < QFIX_MAX_W) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^r_w[QFIX_MAX_W-1:N];
  end

endmodule

// File: rtl/qadd_pipe.sv
// rtl/qadd_pipe.sv - two-stage pipelined multi-lane fixed-point add/sub with overflow counter
module qadd_pipe
  import qfix_pkg::*;
#(
  parameter int Q     = 15,
  parameter int N     = 32,
  parameter int LANES = 1,
  parameter int SAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sub,
  input  logic [LANES*N-1:0]   in_a,
  input  logic [LANES*N-1:0]   in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*N-1:0]   out_c,
  output logic [LANES-1:0]     out_ovf,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     ovf_cnt
);

  if (Q < 0 || Q >= N) begin : g_q_range
    $error("qadd_pipe: Q must lie in [0, N-1]");
  end

  logic                     v1_q, v2_q;
  logic [LANES*(N+1)-1:0]   s_q, s_d;
  logic [LANES*N-1:0]       c_q, c_d;
  logic [LANES-1:0]         ovf_q, ovf_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     rdy1, rdy2, in_xfer, out_xfer, adv;

  assign rdy2     = !v2_q || out_ready;
  assign rdy1     = !v1_q || rdy2;
  assign in_xfer  = in_valid && rdy1;
  assign out_xfer = v2_q && out_ready;
  assign adv      = v1_q && rdy2;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    qadd_lane #(.N(N), .SAT(SAT)) u_lane (
      .a_i   (in_a[i*N +: N]),
      .b_i   (in_b[i*N +: N]),
      .sub_i (in_sub),
      .s_o   (s_d[i*(N+1) +: N+1]),
      .s_i   (s_q[i*(N+1) +: N+1]),
      .c_o   (c_d[i*N +: N]),
      .ovf_o (ovf_d[i])
    );
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_xfer && (|ovf_q) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      s_q   <= '0;
      c_q   <= '0;
      ovf_q <= '0;
      cnt_q <= '0;
    end else begin
      if (rdy1) v1_q <= in_valid;
      if (in_xfer) s_q <= s_d;
      if (rdy2) v2_q <= v1_q;
      if (adv) begin
        c_q   <= c_d;
        ovf_q <= ovf_d;
      end
      cnt_q <= cnt_d;
    end
  end

  assign in_ready  = rdy1;
  assign out_valid = v2_q;
  assign out_c     = c_q;
  assign out_ovf   = ovf_q;
  assign ovf_cnt   = cnt_q;

endmodule

// File: tb/tb_qadd_pipe.sv
// tb/tb_qadd_pipe.sv - directed self-checking bench for qadd_pipe (4-lane saturating and 1-lane wrapping)
module tb_qadd_pipe;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_sub = 1'b0;
  logic [127:0] in_a = '0;
  logic [127:0] in_b = '0;
  logic         out_ready = 1'b1;
  logic         cnt_clr = 1'b0;

  logic         in_ready, out_valid;
  logic [127:0] out_c;
  logic [3:0]   out_ovf;
  logic [15:0]  ovf_cnt;

  logic         w_in_ready, w_out_valid;
  logic [31:0]  w_out_c;
  logic [0:0]   w_out_ovf;
  logic [1:0]   w_ovf_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  qadd_pipe #(.Q(15), .N(32), .LANES(4), .SAT(1), .CNT_W(16)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_ovf(out_ovf), .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt)
  );

  qadd_pipe #(.Q(15), .N(32), .LANES(1), .SAT(0), .CNT_W(2)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .in_sub(in_sub),
    .in_a(in_a[31:0]), .in_b(in_b[31:0]), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_c(w_out_c), .out_ovf(w_out_ovf), .cnt_clr(cnt_clr), .ovf_cnt(w_ovf_cnt)
  );

  // Reference in 64-bit signed arithmetic: {ovf, 32-bit result}.
  function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic sub, input bit sat);
    longint sa, sb, r;
    logic   ovf;
    logic [31:0] c;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    r   = sub ? (sa - sb) : (sa + sb);
    ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    c   = r[31:0];
    if (sat && ovf) c = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    return {ovf, c};
  endfunction

  task automatic drive_beat(input logic [127:0] a, input logic [127:0] b, input logic sub);
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (out_c !== 128'h0 || ovf_cnt !== 16'h0) begin
      n_err++; $display("FAIL reset_regs got c=%h cnt=%h want 0", out_c, ovf_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    drive_beat({32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_8000},
               {32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_8000}, 1'b0);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_early_valid got %b want 0", out_valid); end
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_latency got %b want 1", out_valid); end
    n_vec++; if (out_c !== {32'h8000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h0001_0000}) begin
      n_err++; $display("FAIL add_c got %h want 80000000fffffffe7fffffff00010000", out_c); end
    n_vec++; if (out_ovf !== 4'b1010) begin n_err++; $display("FAIL add_ovf got %b want 1010", out_ovf); end
    n_vec++; if (w_out_c !== 32'h0001_0000 || w_out_ovf !== 1'b0) begin
      n_err++; $display("FAIL add_wrap got %h/%b want 00010000/0", w_out_c, w_out_ovf); end
    @(negedge clk);
    n_vec++; if (ovf_cnt !== 16'd1 || w_ovf_cnt !== 2'd0) begin
      n_err++; $display("FAIL add_cnt got %0d/%0d want 1/0", ovf_cnt, w_ovf_cnt); end
  endtask

  task automatic test_overflow();
    drive_beat({96'h0, 32'h7FFF_FFFF}, {96'h0, 32'h0000_0001}, 1'b0);
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1 || out_c !== {96'h0, 32'h7FFF_FFFF} || out_ovf !== 4'b0001) begin
      n_err++; $display("FAIL ovf_sat got v=%b c=%h o=%b want 1/7fffffff/0001", out_valid, out_c, out_ovf); end
    n_vec++; if (w_out_c !== 32'h8000_0000 || w_out_ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_wrap got %h/%b want 80000000/1", w_out_c, w_out_ovf); end
    @(negedge clk);
    n_vec++; if (ovf_cnt !== 16'd2 || w_ovf_cnt !== 2'd1) begin
      n_err++; $display("FAIL ovf_cnt got %0d/%0d want 2/1", ovf_cnt, w_ovf_cnt); end
  endtask

  task automatic test_sub();
    drive_beat({32'h7FFF_FFFF, 32'h0000_0005, 32'h0000_0000, 32'h8000_0000},
               {32'hFFFF_FFFF, 32'h0000_0007, 32'h8000_0000, 32'h0000_0001}, 1'b1);
    @(negedge clk);
    n_vec++; if (out_c !== {32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000}) begin
      n_err++; $display("FAIL sub_c got %h want 7ffffffffffffffe7fffffff80000000", out_c); end
    n_vec++; if (out_ovf !== 4'b1011) begin n_err++; $display("FAIL sub_ovf got %b want 1011", out_ovf); end
    n_vec++; if (w_out_c !== 32'h7FFF_FFFF || w_out_ovf !== 1'b1) begin
      n_err++; $display("FAIL sub_wrap got %h/%b want 7fffffff/1", w_out_c, w_out_ovf); end
    @(negedge clk);
    n_vec++; if (ovf_cnt !== 16'd3 || w_ovf_cnt !== 2'd2) begin
      n_err++; $display("FAIL sub_cnt got %0d/%0d want 3/2", ovf_cnt, w_ovf_cnt); end
  endtask

  task automatic stream_ovf(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_a = {96'h0, 32'h7FFF_FFFF}; in_b = {96'h0, 32'h0000_0001}; in_sub = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_counter();
    stream_ovf(3);
    n_vec++; if (ovf_cnt !== 16'd6) begin n_err++; $display("FAIL cnt_three got %0d want 6", ovf_cnt); end
    n_vec++; if (w_ovf_cnt !== 2'd3) begin n_err++; $display("FAIL cnt_w_sat got %0d want 3", w_ovf_cnt); end
    drive_beat({96'h0, 32'h7FFF_FFFF}, {96'h0, 32'h0000_0001}, 1'b0);
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1 || out_ovf !== 4'b0001) begin
      n_err++; $display("FAIL clr_beat got v=%b o=%b want 1/0001", out_valid, out_ovf); end
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    n_vec++; if (ovf_cnt !== 16'd0 || w_ovf_cnt !== 2'd0) begin
      n_err++; $display("FAIL clr_prio got %0d/%0d want 0/0", ovf_cnt, w_ovf_cnt); end
    stream_ovf(5);
    n_vec++; if (ovf_cnt !== 16'd5) begin n_err++; $display("FAIL cnt_five got %0d want 5", ovf_cnt); end
    n_vec++; if (w_ovf_cnt !== 2'd3) begin n_err++; $display("FAIL cnt_hold got %0d want 3", w_ovf_cnt); end
  endtask

  task automatic test_back_pressure();
    logic [127:0] qc[$];
    logic [3:0]   qo[$];
    logic [127:0] ec, prev_c;
    logic [3:0]   eo;
    logic [32:0]  r;
    logic         prev_stall;
    int sent, got, stalls;
    sent = 0; got = 0; stalls = 0; prev_stall = 1'b0; prev_c = '0;
    for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (sent < 8) begin
        for (int i = 0; i < 4; i++) begin
          in_a[i*32 +: 32] = 32'h7FFF_FFF8 + 32'(sent * 2 + i);
          in_b[i*32 +: 32] = (i == 3) ? 32'hFFFF_FFF0 : 32'(4 * i);
        end
        in_sub = sent[0];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        n_vec++; if (out_valid !== 1'b1 || out_c !== prev_c) begin
          n_err++; $display("FAIL bp_hold got v=%b c=%h want 1/%h", out_valid, out_c, prev_c); end
      end
      if (in_ready !== 1'b1) begin
        stalls++;
        n_vec++; if (!(out_valid === 1'b1 && out_ready === 1'b0)) begin
          n_err++; $display("FAIL bp_ready got in_ready=%b with v=%b r=%b want v=1 r=0", in_ready, out_valid, out_ready); end
      end
      if (in_valid && in_ready === 1'b1) begin
        for (int i = 0; i < 4; i++) begin
          r = ref_op(in_a[i*32 +: 32], in_b[i*32 +: 32], in_sub, 1'b1);
          ec[i*32 +: 32] = r[31:0];
          eo[i] = r[32];
        end
        qc.push_back(ec); qo.push_back(eo);
        sent++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_vec++;
        if (qc.size() == 0) begin
          n_err++; $display("FAIL bp_extra got c=%h want no beat", out_c);
        end else begin
          ec = qc.pop_front(); eo = qo.pop_front();
          if (out_c !== ec || out_ovf !== eo) begin
            n_err++; $display("FAIL bp_data beat %0d got %h/%b want %h/%b", got, out_c, out_ovf, ec, eo); end
        end
        got++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_c = out_c;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_vec++; if (got != 8) begin n_err++; $display("FAIL bp_count got %0d want 8", got); end
    n_vec++; if (stalls == 0) begin n_err++; $display("FAIL bp_stall got 0 stalls want >0"); end
    repeat (2) @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_dup got v=%b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    @(negedge clk);
    in_a = {96'h0, 32'h7FFF_FFFF}; in_b = {96'h0, 32'h0000_0001}; in_sub = 1'b0; in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL ar_full got rdy=%b v=%b want 0/1", in_ready, out_valid); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0 || out_c !== 128'h0 || out_ovf !== 4'h0) begin
      n_err++; $display("FAIL ar_clear got v=%b c=%h o=%b want 0", out_valid, out_c, out_ovf); end
    n_vec++; if (ovf_cnt !== 16'h0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL ar_cnt got cnt=%0d rdy=%b want 0/1", ovf_cnt, in_ready); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    drive_beat({96'h0, 32'h0000_0001}, {96'h0, 32'h0000_0002}, 1'b0);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ar_early got %b want 0", out_valid); end
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1 || out_c !== {96'h0, 32'h0000_0003}) begin
      n_err++; $display("FAIL ar_first got v=%b c=%h want 1/3", out_valid, out_c); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_sub();
    test_counter();
    test_back_pressure();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
